fb_scanout: RTL and testbench



---
 rtl/fb_scanout.sv | 237 +++++++++++++++++++++++
 tb/tb_fb_scanout.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: places an FB_WIDTH x FB_HEIGHT framebuffer window inside the
// 640x480 active area, paints the border colour around it, optionally
// doubles pixels in both directions via a one-line replay buffer, and
// expands RGB444 / RGB565 source words to COLOR_BITS per channel.
//
// Stream handshake: stream_ena_o is the only qualifier. In any cycle where
// stream_ena_o=1 the source must present stream_data_i and
// stream_err_underflow_i in that same cycle; there is no ready/backpressure
// path back from the stream, and no word is taken when stream_ena_o=0.
//
// Pipeline: stage 1 registers the stream word (or line-buffer read) and the
// syncs, stage 2 registers the colour, so every vga_* output trails de_i /
// hsync_i / vsync_i by exactly two cycles in both scale modes.
module fb_scanout #(
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int X_OFFSET   = 0,
  parameter int Y_OFFSET   = 0,
  parameter int COLOR_BITS = 4
) (
  input  logic                  clk_pix,
  input  logic                  reset_n_i,
  input  logic                  de_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic                  frame_i,
  input  logic                  scale_i,
  input  logic                  pix_fmt_i,
  input  logic [11:0]           border_i,
  input  logic [15:0]           stream_data_i,
  input  logic                  stream_err_underflow_i,
  output logic                  stream_start_frame_o,
  output logic                  stream_ena_o,
  output logic [COLOR_BITS-1:0] vga_r_o,
  output logic [COLOR_BITS-1:0] vga_g_o,
  output logic [COLOR_BITS-1:0] vga_b_o,
  output logic                  vga_hsync_o,
  output logic                  vga_vsync_o,
  output logic                  vga_de_o,
  output logic [15:0]           underflow_cnt_o
);

  localparam int ACT_W = 640;
  localparam int ACT_H = 480;
  localparam int AW    = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;

  // Window edges, clipped to the active area, for 1x and 2x scaling.
  localparam int XE1 = (X_OFFSET + FB_WIDTH      > ACT_W) ? ACT_W : X_OFFSET + FB_WIDTH;
  localparam int XE2 = (X_OFFSET + 2 * FB_WIDTH  > ACT_W) ? ACT_W : X_OFFSET + 2 * FB_WIDTH;
  localparam int YE1 = (Y_OFFSET + FB_HEIGHT     > ACT_H) ? ACT_H : Y_OFFSET + FB_HEIGHT;
  localparam int YE2 = (Y_OFFSET + 2 * FB_HEIGHT > ACT_H) ? ACT_H : Y_OFFSET + 2 * FB_HEIGHT;

  localparam logic [12:0] X_LO  = 13'(X_OFFSET);
  localparam logic [12:0] Y_LO  = 13'(Y_OFFSET);
  localparam logic [12:0] X_HI1 = 13'(XE1);
  localparam logic [12:0] X_HI2 = 13'(XE2);
  localparam logic [12:0] Y_HI1 = 13'(YE1);
  localparam logic [12:0] Y_HI2 = 13'(YE2);

  logic [11:0]   col;
  logic [11:0]   row;
  logic          de_d;
  logic          scale_q;
  logic          fmt_q;

  logic [12:0]   col_x;
  logic [12:0]   row_x;
  logic [AW:0]   dx;
  logic          fy_phase;
  logic          in_x;
  logic          in_y;
  logic          in_win;
  logic [AW-1:0] fx;
  logic          fetch_ena;
  logic          lb_we;
  logic          lb_re;

  logic [16:0]   lbuf [FB_WIDTH];
  logic [16:0]   lbuf_q;

  logic          s1_de;
  logic          s1_hs;
  logic          s1_vs;
  logic          s1_win;
  logic          s1_rep;
  logic [15:0]   s1_word;
  logic          s1_uf;
  logic [16:0]   px;
  logic          px_uf_hit;

  logic [7:0]    r8;
  logic [7:0]    g8;
  logic [7:0]    b8;

  // Column/row position counters and the per-frame mode latches.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      col     <= '0;
      row     <= '0;
      de_d    <= 1'b0;
      scale_q <= 1'b0;
      fmt_q   <= 1'b0;
    end else begin
      de_d <= de_i;
      if (!de_i) begin
        col <= '0;
      end else if (col != 12'hFFF) begin
        col <= col + 12'd1;
      end
      if (frame_i) begin
        row <= '0;
      end else if (de_d && !de_i && (row != 12'hFFF)) begin
        row <= row + 12'd1;
      end
      if (frame_i) begin
        scale_q <= scale_i;
        fmt_q   <= pix_fmt_i;
      end
    end
  end

  // Window membership and framebuffer coordinates of the current pixel.
  assign col_x    = {1'b0, col};
  assign row_x    = {1'b0, row};
  assign dx       = col[AW:0] - X_LO[AW:0];
  assign fy_phase = row[0] ^ Y_LO[0];
  assign in_x     = (col_x >= X_LO) && (col_x < (scale_q ? X_HI2 : X_HI1));
  assign in_y     = (row_x >= Y_LO) && (row_x < (scale_q ? Y_HI2 : Y_HI1));
  assign in_win   = in_x && in_y;
  assign fx       = scale_q ? dx[AW:1] : dx[AW-1:0];

  // 1x takes a word on every window pixel; 2x only on even columns of fetch rows.
  assign fetch_ena = de_i && in_win && (!scale_q || (!fy_phase && !dx[0]));
  assign lb_we     = fetch_ena && scale_q;
  assign lb_re     = de_i && in_win && scale_q && fy_phase;

  assign stream_ena_o         = reset_n_i && fetch_ena;
  assign stream_start_frame_o = frame_i;

  // Line buffer: captures fetched words in 2x mode, replays them on the next row.
  always_ff @(posedge clk_pix) begin
    if (lb_we) begin
      lbuf[fx] <= {stream_err_underflow_i, stream_data_i};
    end
    if (lb_re) begin
      lbuf_q <= lbuf[fx];
    end
  end

  // Stage 1: register syncs and the stream word (held across a 2x pixel pair).
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_win  <= 1'b0;
      s1_rep  <= 1'b0;
      s1_word <= '0;
      s1_uf   <= 1'b0;
    end else begin
      s1_de  <= de_i;
      s1_hs  <= hsync_i;
      s1_vs  <= vsync_i;
      s1_win <= in_win;
      s1_rep <= lb_re;
      if (fetch_ena) begin
        s1_word <= stream_data_i;
        s1_uf   <= stream_err_underflow_i;
      end
    end
  end

  assign px        = s1_rep ? lbuf_q : {s1_uf, s1_word};
  assign px_uf_hit = s1_de && s1_win && px[16];

  function automatic logic [7:0] rep4(input logic [3:0] c);
    return {c, c};
  endfunction

  function automatic logic [7:0] rep5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] rep6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  // Pixel select: blank, border, underflow red, or the expanded source colour.
  always_comb begin
    r8 = '0;
    g8 = '0;
    b8 = '0;
    if (s1_de) begin
      if (!s1_win) begin
        r8 = rep4(border_i[11:8]);
        g8 = rep4(border_i[7:4]);
        b8 = rep4(border_i[3:0]);
      end else if (px[16]) begin
        r8 = 8'hFF;
      end else if (fmt_q) begin
        r8 = rep5(px[15:11]);
        g8 = rep6(px[10:5]);
        b8 = rep5(px[4:0]);
      end else begin
        r8 = rep4(px[11:8]);
        g8 = rep4(px[7:4]);
        b8 = rep4(px[3:0]);
      end
    end
  end

  // Stage 2: register the output colour, syncs and the underflow counter.
  always_ff @(posedge clk_pix or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vga_r_o         <= '0;
      vga_g_o         <= '0;
      vga_b_o         <= '0;
      vga_hsync_o     <= 1'b0;
      vga_vsync_o     <= 1'b0;
      vga_de_o        <= 1'b0;
      underflow_cnt_o <= '0;
    end else begin
      vga_r_o     <= COLOR_BITS'(r8 >> (8 - COLOR_BITS));
      vga_g_o     <= COLOR_BITS'(g8 >> (8 - COLOR_BITS));
      vga_b_o     <= COLOR_BITS'(b8 >> (8 - COLOR_BITS));
      vga_hsync_o <= s1_hs;
      vga_vsync_o <= s1_vs;
      vga_de_o    <= s1_de;
      if (frame_i) begin
        underflow_cnt_o <= '0;
      end else if (px_uf_hit && (underflow_cnt_o != 16'hFFFF)) begin
        underflow_cnt_o <= underflow_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: drives small frames with random stream words and checks
// every enable and every output pixel against a framebuffer-image model.
`timescale 1ns/1ps
module tb_fb_scanout;

  localparam int FW      = 16;
  localparam int FH      = 6;
  localparam int XO      = 5;
  localparam int YO      = 3;
  localparam int CB      = 6;
  localparam int H_ACT   = 40;
  localparam int H_BLANK = 8;
  localparam int V_ACT   = 18;
  localparam int V_BLANK = 2;
  localparam int W       = 3 + 3 * CB;

  logic          clk_pix;
  logic          reset_n_i = 1'b0;
  logic          de_i = 1'b0;
  logic          hsync_i = 1'b0;
  logic          vsync_i = 1'b0;
  logic          frame_i = 1'b0;
  logic          scale_i = 1'b0;
  logic          pix_fmt_i = 1'b0;
  logic [11:0]   border_i = '0;
  logic [15:0]   stream_data_i = '0;
  logic          stream_err_underflow_i = 1'b0;
  logic          stream_start_frame_o;
  logic          stream_ena_o;
  logic [CB-1:0] vga_r_o;
  logic [CB-1:0] vga_g_o;
  logic [CB-1:0] vga_b_o;
  logic          vga_hsync_o;
  logic          vga_vsync_o;
  logic          vga_de_o;
  logic [15:0]   underflow_cnt_o;

  fb_scanout #(
    .FB_WIDTH(FW), .FB_HEIGHT(FH), .X_OFFSET(XO), .Y_OFFSET(YO), .COLOR_BITS(CB)
  ) dut (
    .clk_pix(clk_pix),
    .reset_n_i(reset_n_i),
    .de_i(de_i),
    .hsync_i(hsync_i),
    .vsync_i(vsync_i),
    .frame_i(frame_i),
    .scale_i(scale_i),
    .pix_fmt_i(pix_fmt_i),
    .border_i(border_i),
    .stream_data_i(stream_data_i),
    .stream_err_underflow_i(stream_err_underflow_i),
    .stream_start_frame_o(stream_start_frame_o),
    .stream_ena_o(stream_ena_o),
    .vga_r_o(vga_r_o),
    .vga_g_o(vga_g_o),
    .vga_b_o(vga_b_o),
    .vga_hsync_o(vga_hsync_o),
    .vga_vsync_o(vga_vsync_o),
    .vga_de_o(vga_de_o),
    .underflow_cnt_o(underflow_cnt_o)
  );

  // Clock and watchdog
  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and model state
  int          total = 0;
  int          bad = 0;
  logic [W-1:0] exp_q[$];

  logic [15:0] img_w [FH][FW];
  logic        img_u [FH][FW];
  bit          m_scale = 1'b0;
  bit          m_fmt = 1'b0;
  logic [11:0] m_border = '0;
  bit          chk_en = 1'b1;
  int          uf_exp = 0;
  int          ena_seen = 0;
  int          word_idx = 0;
  int          uf_mode = 0;
  bit          const_mode = 1'b0;
  logic [15:0] const_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // n-bit channel widened to 8 bits by repeating its top bits, then cut to CB.
  function automatic int chan(input int v, input int n);
    int e;
    e = ((v << (8 - n)) | (v >> (2 * n - 8))) & 255;
    return e >> (8 - CB);
  endfunction

  function automatic int lim(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] pack(input bit de, input bit hs, input bit vs,
                                        input int r, input int g, input int b);
    logic [CB-1:0] rc;
    logic [CB-1:0] gc;
    logic [CB-1:0] bc;
    rc = r[CB-1:0];
    gc = g[CB-1:0];
    bc = b[CB-1:0];
    return {de, hs, vs, rc, gc, bc};
  endfunction

  // Driver: one pixel-clock cycle at bench position (r, c).
  task automatic step(input bit de, input bit hs, input bit vs, input bit fr,
                      input int r, input int c);
    int          s;
    int          fx;
    int          fy;
    bit          in_win;
    bit          ena_exp;
    bit          uf;
    logic [15:0] w;
    logic [W-1:0] e;
    @(posedge clk_pix);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("vga", 32'({vga_de_o, vga_hsync_o, vga_vsync_o, vga_r_o, vga_g_o, vga_b_o}), 32'(e));
    end
    s = m_scale ? 2 : 1;
    in_win = de && (c >= XO) && (c < lim(XO + FW * s, 640)) &&
             (r >= YO) && (r < lim(YO + FH * s, 480));
    ena_exp = in_win && (((c - XO) % s) == 0) && (((r - YO) % s) == 0);
    de_i = de;
    hsync_i = hs;
    vsync_i = vs;
    frame_i = fr;
    if (ena_exp) begin
      fx = (c - XO) / s;
      fy = (r - YO) / s;
      w = const_mode ? const_word : 16'($urandom);
      case (uf_mode)
        1: uf = ($urandom_range(0, 9) == 0);
        2: uf = (word_idx < 3);
        default: uf = 1'b0;
      endcase
      word_idx++;
      img_w[fy][fx] = w;
      img_u[fy][fx] = uf;
      stream_data_i = w;
      stream_err_underflow_i = uf;
    end else begin
      stream_data_i = 16'($urandom);
      stream_err_underflow_i = 1'($urandom_range(0, 1));
    end
    #1;
    if (chk_en) check("ena", 32'(stream_ena_o), 32'(ena_exp));
    if (stream_ena_o) ena_seen++;
    if (!de) begin
      e = pack(1'b0, hs, vs, 0, 0, 0);
    end else if (!in_win) begin
      e = pack(1'b1, hs, vs, chan(m_border[11:8], 4), chan(m_border[7:4], 4), chan(m_border[3:0], 4));
    end else begin
      fx = (c - XO) / s;
      fy = (r - YO) / s;
      w = img_w[fy][fx];
      if (img_u[fy][fx]) begin
        e = pack(1'b1, hs, vs, (1 << CB) - 1, 0, 0);
        uf_exp++;
      end else if (m_fmt) begin
        e = pack(1'b1, hs, vs, chan(w[15:11], 5), chan(w[10:5], 6), chan(w[4:0], 5));
      end else begin
        e = pack(1'b1, hs, vs, chan(w[11:8], 4), chan(w[7:4], 4), chan(w[3:0], 4));
      end
    end
    if (chk_en) exp_q.push_back(e);
  endtask

  // Driver: asynchronous reset pulse in the middle of an active line.
  task automatic async_reset_pulse();
    @(posedge clk_pix);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("rst_vga", 32'({vga_de_o, vga_hsync_o, vga_vsync_o, vga_r_o, vga_g_o, vga_b_o}), 32'd0);
    check("rst_cnt", 32'(underflow_cnt_o), 32'd0);
    check("rst_ena", 32'(stream_ena_o), 32'd0);
    frame_i = 1'b1;
    #1;
    check("rst_sof", 32'(stream_start_frame_o), 32'd1);
    frame_i = 1'b0;
    chk_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_pix);
    #1 reset_n_i = 1'b1;
  endtask

  // Driver: one frame. pulse=0 omits frame_i; rst_row>=0 resets mid-line there.
  task automatic run_frame(input bit pulse, input bit scl, input bit fmt, input int ufm,
                           input bit cm, input logic [15:0] cw, input int rst_row);
    uf_mode = ufm;
    const_mode = cm;
    const_word = cw;
    m_border = 12'($urandom);
    border_i = m_border;
    scale_i = scl;
    pix_fmt_i = fmt;
    if (pulse) begin
      chk_en = 1'b1;
      // a one-pixel line whose de falling edge coincides with frame_i
      step(1'b1, 1'b0, 1'b0, 1'b0, 999, 0);
      m_scale = scl;
      m_fmt = fmt;
      uf_exp = 0;
      ena_seen = 0;
      word_idx = 0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      if (chk_en) check("uf_clear", 32'(underflow_cnt_o), 32'd0);
    end else begin
      ena_seen = 0;
      word_idx = 0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    // mode inputs wander mid-frame; only the frame_i cycle value matters
    scale_i = 1'($urandom);
    pix_fmt_i = 1'($urandom);
    for (int r = 0; r < V_ACT; r++) begin
      for (int c = 0; c < H_ACT; c++) begin
        if ((r == rst_row) && (c == 20)) async_reset_pulse();
        step(1'b1, 1'b0, 1'b0, 1'b0, r, c);
      end
      for (int b = 0; b < H_BLANK; b++) step(1'b0, (b >= 2) && (b < 6), 1'b0, 1'b0, r, 0);
    end
    for (int l = 0; l < V_BLANK; l++) begin
      for (int b = 0; b < H_ACT + H_BLANK; b++) step(1'b0, (b >= H_ACT + 2) && (b < H_ACT + 6), 1'b1, 1'b0, 0, 0);
    end
    if (chk_en) begin
      check("uf_cnt", 32'(underflow_cnt_o), 32'(uf_exp));
      check("ena_cnt", 32'(ena_seen), 32'(FW * FH));
    end
  endtask

  // Main sequence and final report
  initial begin
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    check("init_vga", 32'({vga_de_o, vga_hsync_o, vga_vsync_o, vga_r_o, vga_g_o, vga_b_o}), 32'd0);
    check("init_cnt", 32'(underflow_cnt_o), 32'd0);
    check("init_ena", 32'(stream_ena_o), 32'd0);
    check("init_sof0", 32'(stream_start_frame_o), 32'd0);
    frame_i = 1'b1;
    #1;
    check("init_sof1", 32'(stream_start_frame_o), 32'd1);
    frame_i = 1'b0;
    @(posedge clk_pix);
    #1 reset_n_i = 1'b1;
    m_scale = 1'b0;
    m_fmt = 1'b0;
    uf_exp = 0;

    // no frame_i yet: reset values (1x, RGB444) apply despite scale_i/pix_fmt_i=1
    run_frame(1'b0, 1'b1, 1'b1, 1, 1'b0, 16'h0000, -1);
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b1, 16'h0ABC, -1);
    run_frame(1'b1, 1'b0, 1'b1, 0, 1'b1, 16'hF81F, -1);
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b1, 16'h05A0, -1);
    run_frame(1'b1, 1'b1, 1'b0, 2, 1'b0, 16'h0000, -1);
    check("uf_12", 32'(underflow_cnt_o), 32'd12);
    run_frame(1'b1, 1'b1, 1'b1, 1, 1'b0, 16'h0000, -1);
    run_frame(1'b1, 1'b0, 1'b1, 1, 1'b0, 16'h0000, -1);
    run_frame(1'b1, 1'b1, 1'b0, 1, 1'b0, 16'h0000, 8);
    run_frame(1'b1, 1'b1, 1'b0, 1, 1'b0, 16'h0000, -1);
    run_frame(1'b1, 1'b0, 1'b0, 1, 1'b0, 16'h0000, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
